// File: rtl/writeback_pkg.sv
// Shared types and constants for the register file writeback path.
// Contents: register file geometry, the queued entry type (wb_entry_t) and
// the is_zero_reg helper used to drop writes to the hardwired zero register.
package writeback_pkg;

    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned REG_ADDR_W = $clog2(NUM_REGS);
    localparam int unsigned REG_DATA_W = 32;

    // One pending register file write.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

    // Register 0 is hardwired; writes to it are discarded.
    function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] r);
        return (r == '0);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order synchronous FIFO of wb_entry_t.
// Ports:
//   clock, reset         rising-edge clock, async active-high reset
//   push, wdata          enqueue request and entry (ignored when full)
//   pop                  dequeue request (ignored when empty)
//   full, empty, count   occupancy status
//   head                 oldest entry
//   entries, valid       raw storage and occupancy mask for lookup logic
//   head_ptr             index of the oldest entry, for age ordering
module wb_fifo
    import writeback_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        push,
    input  wb_entry_t                   wdata,
    input  logic                        pop,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(DEPTH):0]      count,
    output wb_entry_t                   head,
    output wb_entry_t [DEPTH-1:0]       entries,
    output logic [DEPTH-1:0]            valid,
    output logic [$clog2(DEPTH)-1:0]    head_ptr
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]      head_q;
    logic [PTR_W-1:0]      tail_q;
    logic [CNT_W-1:0]      count_q;
    wb_entry_t [DEPTH-1:0] mem_q;
    logic [DEPTH-1:0]      valid_q;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage, pointers and occupancy; pointers wrap naturally (DEPTH is a power of two).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            mem_q   <= '0;
            valid_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[tail_q]   <= wdata;
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PTR_W'(1);
            end
            // Head and tail never coincide when both move (not full, not empty).
            if (do_pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign count    = count_q;
    assign head     = mem_q[head_q];
    assign entries  = mem_q;
    assign valid    = valid_q;
    assign head_ptr = head_q;

endmodule

// File: rtl/writeback_queue.sv
// Writeback queue in front of the register file write port.
// Buffers accepted writeback requests in order and drains one per cycle.
// Optional macro WRITEBACK_QUEUE_LOOKUP_EN builds the youngest-match
// bypass lookup; otherwise lookup outputs are tied to zero.
// Ports:
//   clock, reset                       rising-edge clock, async active-high reset
//   in_valid/in_ready/in_reg/in_data  writeback request handshake
//   rf_stall                           register file port busy this cycle
//   rf_write_reg/data/enable           register file write port (head entry)
//   lookup_reg1/2, lookup_hit1/2,
//   lookup_data1/2                     bypass queries against pending writes
//   count                              occupied entries
module writeback_queue
    import writeback_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ADDR_WIDTH-1:0]     in_reg,
    input  logic [DATA_WIDTH-1:0]     in_data,
    input  logic                      rf_stall,
    output logic [ADDR_WIDTH-1:0]     rf_write_reg,
    output logic [DATA_WIDTH-1:0]     rf_write_data,
    output logic                      rf_write_enable,
    input  logic [ADDR_WIDTH-1:0]     lookup_reg1,
    input  logic [ADDR_WIDTH-1:0]     lookup_reg2,
    output logic                      lookup_hit1,
    output logic                      lookup_hit2,
    output logic [DATA_WIDTH-1:0]     lookup_data1,
    output logic [DATA_WIDTH-1:0]     lookup_data2,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    wb_entry_t             in_entry;
    wb_entry_t             head_entry;
    wb_entry_t [DEPTH-1:0] entries;
    logic [DEPTH-1:0]      valid;
    logic [PTR_W-1:0]      head_ptr;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  accept;
    logic                  push;

    assign in_entry = '{dest: REG_ADDR_W'(in_reg), data: REG_DATA_W'(in_data)};

    // Ready depends only on occupancy; zero-register requests handshake but are dropped.
    assign in_ready = !fifo_full;
    assign accept   = in_valid && in_ready;
    assign push     = accept && !is_zero_reg(in_entry.dest);

    // Head drains whenever the register file port is free; pop on the commit edge.
    assign rf_write_enable = !fifo_empty && !rf_stall;
    assign rf_write_reg    = fifo_empty ? '0 : ADDR_WIDTH'(head_entry.dest);
    assign rf_write_data   = fifo_empty ? '0 : DATA_WIDTH'(head_entry.data);

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .wdata    (in_entry),
        .pop      (rf_write_enable),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (count),
        .head     (head_entry),
        .entries  (entries),
        .valid    (valid),
        .head_ptr (head_ptr)
    );

`ifdef WRITEBACK_QUEUE_LOOKUP_EN
    logic [REG_ADDR_W-1:0] query1;
    logic [REG_ADDR_W-1:0] query2;
    logic [PTR_W-1:0]      lk_idx;

    assign query1 = REG_ADDR_W'(lookup_reg1);
    assign query2 = REG_ADDR_W'(lookup_reg2);

    // Walk oldest to youngest so the last match (closest to tail) wins.
    always_comb begin
        lookup_hit1  = 1'b0;
        lookup_hit2  = 1'b0;
        lookup_data1 = '0;
        lookup_data2 = '0;
        lk_idx       = '0;
        for (int k = 0; k < DEPTH; k++) begin
            lk_idx = head_ptr + PTR_W'(k);
            if (valid[lk_idx] && !is_zero_reg(query1) && (entries[lk_idx].dest == query1)) begin
                lookup_hit1  = 1'b1;
                lookup_data1 = DATA_WIDTH'(entries[lk_idx].data);
            end
            if (valid[lk_idx] && !is_zero_reg(query2) && (entries[lk_idx].dest == query2)) begin
                lookup_hit2  = 1'b1;
                lookup_data2 = DATA_WIDTH'(entries[lk_idx].data);
            end
        end
    end
`else
    logic unused_lookup;

    assign unused_lookup = ^{lookup_reg1, lookup_reg2, entries, valid, head_ptr};
    assign lookup_hit1   = 1'b0;
    assign lookup_hit2   = 1'b0;
    assign lookup_data1  = '0;
    assign lookup_data2  = '0;
`endif

endmodule
